// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status strobes out.
interface uart_rx_if;
    logic       i_signal;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frame_error;

    modport master (
        output i_signal,
        input  o_data, o_valid, o_busy, o_frame_error
    );

    modport slave (
        input  i_signal,
        output o_data, o_valid, o_busy, o_frame_error
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: two-flop line synchroniser, mid-bit sampling,
// one-cycle valid / framing-error strobes, break hold-off after a bad stop bit.
module uart_rx #(
    parameter int unsigned CLOCKS_PER_BIT = 16
) (
    input  logic     i_clock,
    input  logic     i_reset,
    uart_rx_if.slave bus
);

    localparam int unsigned HALF = CLOCKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          busy_q;
    logic          ferr_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= bus.i_signal;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            // busy follows the current state one cycle later, so it never glitches
            busy_q  <= (state_q != IDLE);

            case (state_q)
                IDLE: begin
                    if (!sync2_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= sync2_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    // hold off until the line returns high so a long break is one error
                    if (sync2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.o_data        = data_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_frame_error = ferr_q;

endmodule
